// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Two-requester arbiter in front of port A of the shared 1024x16 dual-port
// memory. Requester 0 is the game/board logic and requester 1 is the
// display/score reader. Accesses are serialised and each one takes four
// cycles: IDLE (grant), ISSUE, WAIT, then ACK. This covers the memory's
// registered read: q_a is valid the cycle after the address edge, and it is
// captured into rdata on entry to ACK.
//
// Ports
//   clock, reset_n            rising-edge clock, asynchronous active-low reset
//   req0/we0/addr0/wdata0     requester 0 request; held stable until ack0
//   ack0                      one-cycle completion pulse to requester 0
//   req1/we1/addr1/wdata1     requester 1 request; held stable until ack1
//   ack1                      one-cycle completion pulse to requester 1
//   rdata                     read data, valid in the ack cycle (shared)
//   mem_addr/mem_data/mem_we  to memory addr_a / data_a / we_a
//   mem_q                     from memory q_a
//   busy                      high whenever the FSM is not in IDLE
//
// Configuration macro
//   ARB_FIXED_PRIO_EN  When defined, requester 0 always wins a tie and no
//                      round-robin pointer is built. When undefined (the
//                      default), ties are resolved round-robin.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t state;
  logic   owner;   // requester currently being served
  logic   cur_we;  // latched direction of the current access
  logic   grant1;  // requester 1 would be chosen if a grant happens now

`ifdef ARB_FIXED_PRIO_EN
  assign grant1 = req1 & ~req0;
`else
  // prefer1 names the requester that wins the next tie. It points away
  // from whoever was granted last.
  logic prefer1;
  assign grant1 = req1 & (~req0 | prefer1);
`endif

  // The memory-facing registers double as the request latch: they are loaded
  // once at grant time and later changes on the requester inputs are ignored.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      owner    <= 1'b0;
      cur_we   <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      busy     <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      rdata    <= '0;
`ifndef ARB_FIXED_PRIO_EN
      prefer1  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner    <= grant1;
            cur_we   <= grant1 ? we1 : we0;
            mem_we   <= grant1 ? we1 : we0;
            mem_addr <= grant1 ? addr1 : addr0;
            mem_data <= grant1 ? wdata1 : wdata0;
            busy     <= 1'b1;
`ifndef ARB_FIXED_PRIO_EN
            prefer1  <= ~grant1;
`endif
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          // The write strobe lasts exactly one cycle; the address stays put.
          mem_we <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          // mem_q now holds the word addressed during ISSUE.
          if (!cur_we) begin
            rdata <= mem_q;
          end
          ack0  <= ~owner;
          ack1  <= owner;
          state <= ACK;
        end
        ACK: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
